control_fsm_mc: RTL

Parametrised multi-cycle control unit for the single-issue processor. It sequences each instruction FETCH→DECODE→EXECUTE→(MEMORY)→UPDATE_PC. Over the previous controller it adds: a latched opcode, a memory ready handshake with timeout, a stall input, an edge-triggered resume from HALT, illegal-opcode trapping, and a retired-instruction counter. It drives the PC, register file, memory and datapath muxes from Moore-style decode of the registered state and latched opcode.

---
 rtl/ctrl_pkg.sv | 69 ++++++
 rtl/cont_sync_edge.sv | 25 ++
 rtl/control_fsm_mc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, state, BRANCH and DataSel encodings for the multi-cycle controller and datapath.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package ctrl_pkg;

   // Opcodes, low nibble; 4'hA..4'hD are unassigned and treated as illegal
   localparam logic [3:0] OP_ALU     = 4'h0;
   localparam logic [3:0] OP_ALU_IMM = 4'h1;
   localparam logic [3:0] OP_LOAD    = 4'h2;
   localparam logic [3:0] OP_STORE   = 4'h3;
   localparam logic [3:0] OP_BR      = 4'h4;
   localparam logic [3:0] OP_BMI     = 4'h5;
   localparam logic [3:0] OP_BPL     = 4'h6;
   localparam logic [3:0] OP_BZ      = 4'h7;
   localparam logic [3:0] OP_MOVE    = 4'h8;
   localparam logic [3:0] OP_CMOV    = 4'h9;
   localparam logic [3:0] OP_NOP     = 4'hE;
   localparam logic [3:0] OP_HALT    = 4'hF;

   // FSM state encodings (exported on the debug state port)
   localparam logic [2:0] ST_FETCH     = 3'b000;
   localparam logic [2:0] ST_DECODE    = 3'b001;
   localparam logic [2:0] ST_EXECUTE   = 3'b010;
   localparam logic [2:0] ST_MEMORY    = 3'b011;
   localparam logic [2:0] ST_UPDATE_PC = 3'b100;
   localparam logic [2:0] ST_HALTED    = 3'b101;
   localparam logic [2:0] ST_ERROR     = 3'b110;

   // BRANCH codes
   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BR   = 3'b001;
   localparam logic [2:0] BR_BMI  = 3'b010;
   localparam logic [2:0] BR_BPL  = 3'b011;
   localparam logic [2:0] BR_BZ   = 3'b100;

   // DataSel codes
   localparam logic [1:0] DS_ALU  = 2'b00;
   localparam logic [1:0] DS_MEM  = 2'b01;
   localparam logic [1:0] DS_CMOV = 2'b10;

   // All control strobes and mux selects driven towards the datapath
   typedef struct packed {
      logic       load_pc;
      logic       rst_pc;
      logic       write_reg;
      logic       rst_reg;
      logic       mem_en;
      logic       mem_wen;
      logic       imm_sel;
      logic [1:0] data_sel;
      logic [2:0] branch;
      logic       halted;
   } ctrl_out_t;

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_BR) || (op == OP_BMI) || (op == OP_BPL) || (op == OP_BZ);
   endfunction

   function automatic logic [2:0] branch_code(input logic [3:0] op);
      case (op)
         OP_BR:   return BR_BR;
         OP_BMI:  return BR_BMI;
         OP_BPL:  return BR_BPL;
         OP_BZ:   return BR_BZ;
         default: return BR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/cont_sync_edge.sv
// Synchronises the asynchronous resume push-button and turns its rising edge into a single-cycle pulse.
// Latency: pulse is high in the cycle after the second rising clk edge that sees the input high.
// Backpressure: none; a level held high produces exactly one pulse until it drops again.
// Ports: clk, reset (async active-low), async_in (raw button level), pulse (one-cycle rising-edge strobe).
module cont_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic pulse
);

   // sync_q[0..1] are the two synchroniser flops; sync_q[2] is the previous synchronised level
   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
      end
   end

   assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/control_fsm_mc.sv
// Multi-cycle control FSM: FETCH, DECODE, EXECUTE, (MEMORY), UPDATE_PC with halt/resume, traps and retire count.
// Latency: ALU/branch/NOP retire in 4 cycles; LOAD/STORE in 5 plus memory wait cycles.
// Backpressure: stall holds FETCH and UPDATE_PC; mem_ready holds MEMORY up to MEM_TIMEOUT cycles, then bus error.
// Ports: clk, reset (async active-low), cont (resume button), stall, op_code, mem_ready;
//        datapath strobes loadPC/rstPC/writeReg/rstReg/MemEn/MemWen/IMMsel/DataSel/BRANCH;
//        status halted/illegal_op/bus_err, debug state, retired-instruction count instr_count.
module control_fsm_mc #(
   parameter int OPCODE_W        = 4,
   parameter int CNT_W           = 32,
   parameter int MEM_TIMEOUT     = 16,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cont,
   input  logic                stall,
   input  logic [OPCODE_W-1:0] op_code,
   input  logic                mem_ready,
   output logic                loadPC,
   output logic                rstPC,
   output logic                writeReg,
   output logic                rstReg,
   output logic                MemEn,
   output logic                MemWen,
   output logic                IMMsel,
   output logic [1:0]          DataSel,
   output logic [2:0]          BRANCH,
   output logic                halted,
   output logic                illegal_op,
   output logic                bus_err,
   output logic [2:0]          state,
   output logic [CNT_W-1:0]    instr_count
);

   import ctrl_pkg::*;

   // Wide enough to hold MEM_TIMEOUT-1, the last waiting cycle before the bus error
   localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

   logic [2:0]          state_q, state_d;
   logic [OPCODE_W-1:0] op_q;
   logic [TMR_W-1:0]    tmr_q;
   logic [CNT_W-1:0]    instr_count_q;
   logic                illegal_q;
   logic                bus_err_q;
   logic                rst_q;

   logic                cont_pulse;
   logic                hi_bits;
   logic                op_illegal;
   logic [3:0]          op_lo;
   logic [3:0]          op_eff;

   logic                tmr_clr;
   logic                tmr_inc;
   logic                trap_ill;
   logic                trap_bus;
   logic                retire;

   ctrl_out_t           co;

   cont_sync_edge u_cont_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (cont),
      .pulse    (cont_pulse)
   );

   // Any set bit above the low nibble makes the opcode illegal
   generate
      if (OPCODE_W > 4) begin : g_wide_op
         assign hi_bits = |op_q[OPCODE_W-1:4];
      end else begin : g_narrow_op
         assign hi_bits = 1'b0;
      end
   endgenerate

   assign op_lo      = op_q[3:0];
   assign op_illegal = hi_bits || ((op_lo >= 4'hA) && (op_lo <= 4'hD));
   // Illegal opcodes decode as NOP, so with trapping disabled they simply retire
   assign op_eff     = op_illegal ? OP_NOP : op_lo;

   // Next-state and side-effect decode
   always_comb begin
      state_d  = state_q;
      tmr_clr  = 1'b0;
      tmr_inc  = 1'b0;
      trap_ill = 1'b0;
      trap_bus = 1'b0;
      retire   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (!stall) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (op_illegal && HALT_ON_ILLEGAL) begin
               trap_ill = 1'b1;
               state_d  = ST_ERROR;
            end else begin
               case (op_eff)
                  OP_LOAD, OP_STORE: begin
                     tmr_clr = 1'b1;
                     state_d = ST_MEMORY;
                  end
                  OP_HALT: state_d = ST_HALTED;
                  default: state_d = ST_UPDATE_PC;
               endcase
            end
         end
         ST_MEMORY: begin
            if (mem_ready) begin
               state_d = ST_UPDATE_PC;
            end else if (tmr_q == TMR_LAST) begin
               trap_bus = 1'b1;
               state_d  = ST_ERROR;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_UPDATE_PC: begin
            if (!stall) begin
               retire  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_HALTED: begin
            if (cont_pulse) state_d = ST_UPDATE_PC;
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            // Unused encoding 3'b111 can only come from an upset; park safely
            state_d = ST_ERROR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_FETCH;
         op_q          <= '0;
         tmr_q         <= '0;
         instr_count_q <= '0;
         illegal_q     <= 1'b0;
         bus_err_q     <= 1'b0;
         rst_q         <= 1'b1;
      end else begin
         // rst_q keeps PC and register file in reset for one cycle after release
         rst_q   <= 1'b0;
         state_q <= state_d;
         if (state_q == ST_DECODE) op_q <= op_code;
         if (tmr_clr) begin
            tmr_q <= '0;
         end else if (tmr_inc) begin
            tmr_q <= tmr_q + 1'b1;
         end
         if (retire)   instr_count_q <= instr_count_q + 1'b1;
         if (trap_ill) illegal_q     <= 1'b1;
         if (trap_bus) bus_err_q     <= 1'b1;
      end
   end

   // Moore-style output decode from state and latched opcode; only the LOAD
   // register write in MEMORY looks at mem_ready so data is captured in the ready cycle
   always_comb begin
      co         = '0;
      co.rst_pc  = rst_q;
      co.rst_reg = rst_q;
      case (state_q)
         ST_EXECUTE: begin
            case (op_eff)
               OP_ALU, OP_MOVE: co.write_reg = 1'b1;
               OP_ALU_IMM: begin
                  co.write_reg = 1'b1;
                  co.imm_sel   = 1'b1;
               end
               OP_CMOV: begin
                  co.write_reg = 1'b1;
                  co.data_sel  = DS_CMOV;
               end
               OP_BR, OP_BMI, OP_BPL, OP_BZ: begin
                  co.imm_sel = 1'b1;
                  co.branch  = branch_code(op_eff);
               end
               default: ;
            endcase
         end
         ST_MEMORY: begin
            co.mem_en  = 1'b1;
            co.imm_sel = 1'b1;
            if (op_eff == OP_STORE) co.mem_wen = 1'b1;
            if (op_eff == OP_LOAD) begin
               co.data_sel  = DS_MEM;
               co.write_reg = mem_ready;
            end
         end
         ST_UPDATE_PC: begin
            // Branch target selection stays stable while the PC is loaded
            if (is_branch(op_eff)) begin
               co.imm_sel = 1'b1;
               co.branch  = branch_code(op_eff);
            end
            co.load_pc = !stall;
         end
         ST_HALTED: begin
            co.halted = 1'b1;
         end
         default: ;
      endcase
   end

   assign loadPC      = co.load_pc;
   assign rstPC       = co.rst_pc;
   assign writeReg    = co.write_reg;
   assign rstReg      = co.rst_reg;
   assign MemEn       = co.mem_en;
   assign MemWen      = co.mem_wen;
   assign IMMsel      = co.imm_sel;
   assign DataSel     = co.data_sel;
   assign BRANCH      = co.branch;
   assign halted      = co.halted;
   assign illegal_op  = illegal_q;
   assign bus_err     = bus_err_q;
   assign state       = state_q;
   assign instr_count = instr_count_q;

endmodule
